// File: rtl/vga_fetch_scheduler_if.sv
// Framebuffer read port shared by display refresh and GPU bursts.
// Request is held until ack; rdata is valid in the ack cycle.
interface vga_fetch_scheduler_if #(
    parameter int ADDR_W = 20
) ();
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_rd, mem_addr,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_rd, mem_addr,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/vga_fetch_scheduler.sv
// Framebuffer fetch scheduler: ping-pong line prefetch with GPU burst sharing.
// Optional FETCH_STATS_EN adds underrun_cnt / gpu_stall_cnt outputs.
module vga_fetch_scheduler #(
    parameter int          HACTIVE      = 800,
    parameter int          VACTIVE      = 600,
    parameter int          PIX_PER_WORD = 4,
    parameter int          ADDR_W       = 20,
    parameter int unsigned FB_BASE      = 0,
    parameter int          LEN_W        = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tim_frame_start,
    input  logic              tim_line_done,
    input  logic [15:0]       tim_y,
    vga_fetch_scheduler_if.master mem,
    output logic              lb_we,
    output logic              lb_bank,
    output logic [7:0]        lb_waddr,
    output logic [31:0]       lb_wdata,
    output logic              disp_bank,
    input  logic              gpu_req,
    input  logic [ADDR_W-1:0] gpu_addr,
    input  logic [LEN_W-1:0]  gpu_len,
    output logic              gpu_gnt,
    output logic              gpu_rvalid,
    output logic              gpu_done,
    output logic              underrun
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]       underrun_cnt,
    output logic [15:0]       gpu_stall_cnt
`endif
);
    localparam int                LW    = HACTIVE / PIX_PER_WORD;
    localparam logic [7:0]        LAST  = 8'(LW - 1);
    localparam logic [ADDR_W-1:0] LW_A  = ADDR_W'(LW);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(FB_BASE);

    typedef enum logic [1:0] {IDLE, DISP, GPU} state_t;

    state_t            state;
    logic              disp_pend;
    logic [7:0]        wcnt;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] gpu_ptr;
    logic [LEN_W-1:0]  gpu_rem;
    logic              gpu_act;

    logic trig, d_ack, g_ack, d_last, late;
    logic [LEN_W-1:0] len_eff;

    assign trig    = tim_frame_start |
                     (tim_line_done & (tim_y < 16'(VACTIVE - 1)));
    assign d_ack   = (state == DISP) & mem.mem_ack;
    assign g_ack   = (state == GPU) & mem.mem_ack;
    assign d_last  = d_ack & (wcnt == LAST);
    // A trigger landing on the final ack of a fill is on time, not late
    assign late    = trig & (disp_pend | ((state == DISP) & ~d_last));
    assign len_eff = (gpu_len == '0) ? LEN_W'(1) : gpu_len;

    assign mem.mem_rd = (state != IDLE);
    assign lb_we      = d_ack;
    assign lb_waddr   = wcnt;
    assign lb_wdata   = d_ack ? mem.mem_rdata : 32'h0;
    assign gpu_rvalid = g_ack;

    always_comb begin
        mem.mem_addr = '0;
        unique case (state)
            DISP:    mem.mem_addr = line_base + ADDR_W'(wcnt);
            GPU:     mem.mem_addr = gpu_ptr;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            disp_pend <= 1'b0;
            wcnt      <= '0;
            line_base <= BASE;
            gpu_ptr   <= '0;
            gpu_rem   <= '0;
            gpu_act   <= 1'b0;
            lb_bank   <= 1'b0;
            disp_bank <= 1'b0;
            gpu_gnt   <= 1'b0;
            gpu_done  <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            gpu_gnt  <= 1'b0;
            gpu_done <= 1'b0;
            if (late) underrun <= 1'b1;
            if (tim_frame_start) line_base <= BASE;
            else if (trig) line_base <= line_base + LW_A;
            if (trig && !((state == DISP) && !d_last)) disp_pend <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (disp_pend) begin
                        state     <= DISP;
                        wcnt      <= '0;
                        disp_pend <= 1'b0;
                    end else if (gpu_act) begin
                        state <= GPU;
                    end else if (gpu_req) begin
                        state   <= GPU;
                        gpu_gnt <= 1'b1;
                        gpu_ptr <= gpu_addr;
                        gpu_rem <= len_eff;
                        gpu_act <= 1'b1;
                    end
                end
                DISP: begin
                    if (trig && !d_last) begin
                        wcnt <= '0;
                    end else if (d_ack) begin
                        if (d_last) begin
                            wcnt      <= '0;
                            disp_bank <= lb_bank;
                            lb_bank   <= ~lb_bank;
                            state     <= IDLE;
                        end else begin
                            wcnt <= wcnt + 8'd1;
                        end
                    end
                end
                GPU: begin
                    if (g_ack) begin
                        gpu_ptr <= gpu_ptr + ADDR_W'(1);
                        gpu_rem <= gpu_rem - LEN_W'(1);
                        if (gpu_rem == LEN_W'(1)) begin
                            gpu_done <= 1'b1;
                            gpu_act  <= 1'b0;
                            state    <= IDLE;
                        end else if (disp_pend) begin
                            state     <= DISP;
                            wcnt      <= '0;
                            disp_pend <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrun_cnt  <= '0;
            gpu_stall_cnt <= '0;
        end else if (tim_frame_start) begin
            underrun_cnt  <= '0;
            gpu_stall_cnt <= '0;
        end else begin
            if (late && underrun_cnt != 16'hffff)
                underrun_cnt <= underrun_cnt + 16'd1;
            if (gpu_req && !gpu_gnt && gpu_stall_cnt != 16'hffff)
                gpu_stall_cnt <= gpu_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_fetch_scheduler.sv
// Directed bench for vga_fetch_scheduler: line prefetch, GPU bursts,
// preemption, underrun restart, reset abort and end-of-fill trigger.
module tb_vga_fetch_scheduler;
    logic        clk;
    logic        rst;
    logic        tim_frame_start, tim_line_done;
    logic [15:0] tim_y;
    logic        lb_we, lb_bank, disp_bank;
    logic [7:0]  lb_waddr;
    logic [31:0] lb_wdata;
    logic        gpu_req;
    logic [19:0] gpu_addr;
    logic [4:0]  gpu_len;
    logic        gpu_gnt, gpu_rvalid, gpu_done, underrun;
`ifdef FETCH_STATS_EN
    logic [15:0] underrun_cnt, gpu_stall_cnt;
`endif

    vga_fetch_scheduler_if #(.ADDR_W(20)) mif ();

    vga_fetch_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .tim_frame_start(tim_frame_start),
        .tim_line_done  (tim_line_done),
        .tim_y          (tim_y),
        .mem            (mif),
        .lb_we          (lb_we),
        .lb_bank        (lb_bank),
        .lb_waddr       (lb_waddr),
        .lb_wdata       (lb_wdata),
        .disp_bank      (disp_bank),
        .gpu_req        (gpu_req),
        .gpu_addr       (gpu_addr),
        .gpu_len        (gpu_len),
        .gpu_gnt        (gpu_gnt),
        .gpu_rvalid     (gpu_rvalid),
        .gpu_done       (gpu_done),
        .underrun       (underrun)
`ifdef FETCH_STATS_EN
        ,
        .underrun_cnt   (underrun_cnt),
        .gpu_stall_cnt  (gpu_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    `define CHK(tag, obs, exp) \
        nvec++; \
        assert ((obs) === (exp)) else begin \
            nerr++; \
            $error("FAIL %s: got %0h want %0h", tag, obs, exp); \
        end

    // Memory model plus transaction recorder
    bit          ack_en = 0;
    int          ack_dly = 0;
    int          wait_n = 0;
    int          cyc = 0;
    logic [28:0] disp_q[$];
    logic [19:0] gpu_q[$];
    int          rd_cyc, gnt_n, done_n, done_cyc, last_rv, wdata_bad;
    int          gpu_before;
    bit          seen_disp;

    always @(negedge clk) begin
        if (mif.mem_rd && ack_en && wait_n >= ack_dly) begin
            mif.mem_ack = 1'b1;
            wait_n = 0;
        end else begin
            mif.mem_ack = 1'b0;
            if (mif.mem_rd && ack_en) wait_n++;
            else wait_n = 0;
        end
        mif.mem_rdata = {12'hA5C, mif.mem_addr};
        #1;
        cyc++;
        if (mif.mem_rd) rd_cyc++;
        if (lb_we) begin
            if (!seen_disp) begin
                seen_disp = 1;
                gpu_before = gpu_q.size();
            end
            disp_q.push_back({lb_bank, lb_waddr, mif.mem_addr});
            if (lb_wdata !== {12'hA5C, mif.mem_addr}) wdata_bad++;
        end
        if (gpu_rvalid) begin
            gpu_q.push_back(mif.mem_addr);
            last_rv = cyc;
        end
        if (gpu_gnt) gnt_n++;
        if (gpu_done) begin
            done_n++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    task automatic clr();
        disp_q.delete();
        gpu_q.delete();
        rd_cyc = 0; gnt_n = 0; done_n = 0; done_cyc = -1;
        last_rv = -2; wdata_bad = 0; gpu_before = -1; seen_disp = 0;
    endtask

    function automatic int disp_bad(int from, int n, int base, bit bank);
        int b = 0;
        if (disp_q.size() < from + n) return n;
        for (int i = 0; i < n; i++)
            if (disp_q[from+i] !== {bank, 8'(i), 20'(base + i)}) b++;
        return b;
    endfunction

    function automatic int gpu_bad(int n, int base);
        int b = 0;
        if (gpu_q.size() < n) return n;
        for (int i = 0; i < n; i++)
            if (gpu_q[i] !== 20'(base + i)) b++;
        return b;
    endfunction

    task automatic gpu_burst(input logic [19:0] a, input logic [4:0] l);
        gpu_addr = a;
        gpu_len  = l;
        gpu_req  = 1'b1;
        for (int k = 0; k < 20 && !gpu_gnt; k++) tick();
        gpu_req = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        tim_frame_start = 0; tim_line_done = 0; tim_y = '0;
        gpu_req = 0; gpu_addr = '0; gpu_len = '0;
        mif.mem_ack = 0; mif.mem_rdata = '0;
        clr();
        repeat (3) tick();

        `CHK("rst_mem_rd", mif.mem_rd, 1'b0)
        `CHK("rst_mem_addr", mif.mem_addr, 20'h0)
        `CHK("rst_lb_bank", lb_bank, 1'b0)
        `CHK("rst_disp_bank", disp_bank, 1'b0)
        `CHK("rst_gnt", gpu_gnt, 1'b0)
        `CHK("rst_done", gpu_done, 1'b0)
        `CHK("rst_underrun", underrun, 1'b0)
        rst = 1'b1;
        tick();

        // Line 0 after frame start, ack every cycle
        clr();
        ack_en = 1; ack_dly = 0;
        tim_frame_start = 1; tick(); tim_frame_start = 0;
        for (int k = 0; k < 300 && disp_q.size() < 200; k++) tick();
        repeat (3) tick();
        `CHK("l0_count", disp_q.size(), 200)
        `CHK("l0_seq", disp_bad(0, 200, 0, 1'b0), 0)
        `CHK("l0_wdata", wdata_bad, 0)
        `CHK("l0_disp_bank", disp_bank, 1'b0)
        `CHK("l0_lb_bank", lb_bank, 1'b1)
        `CHK("l0_underrun", underrun, 1'b0)
        `CHK("l0_idle", mif.mem_rd, 1'b0)

        // Line 1 into bank 1
        clr();
        tim_line_done = 1; tim_y = 16'd0; tick(); tim_line_done = 0;
        for (int k = 0; k < 300 && disp_q.size() < 200; k++) tick();
        repeat (3) tick();
        `CHK("l1_seq", disp_bad(0, 200, 200, 1'b1), 0)
        `CHK("l1_disp_bank", disp_bank, 1'b1)
        `CHK("l1_lb_bank", lb_bank, 1'b0)

        // Last visible line: no fetch
        clr();
        tim_line_done = 1; tim_y = 16'd599; tick(); tim_line_done = 0;
        repeat (10) tick();
        `CHK("y599_no_rd", rd_cyc, 0)

        // GPU burst of 8 words
        clr();
        gpu_burst(20'h8000, 5'd8);
        for (int k = 0; k < 40 && done_n == 0; k++) tick();
        repeat (3) tick();
        `CHK("g8_gnt", gnt_n, 1)
        `CHK("g8_count", gpu_q.size(), 8)
        `CHK("g8_seq", gpu_bad(8, 32'h8000), 0)
        `CHK("g8_done_n", done_n, 1)
        `CHK("g8_done_cyc", done_cyc, last_rv + 1)

        // Zero length behaves as one word
        clr();
        gpu_burst(20'h00123, 5'd0);
        for (int k = 0; k < 20 && done_n == 0; k++) tick();
        repeat (3) tick();
        `CHK("g0_count", gpu_q.size(), 1)
        `CHK("g0_seq", gpu_bad(1, 32'h123), 0)
        `CHK("g0_done_n", done_n, 1)

        // Display preempts a 16-word burst after the in-flight word
        clr();
        ack_dly = 2;
        gpu_burst(20'h9000, 5'd16);
        for (int k = 0; k < 100 && gpu_q.size() < 5; k++) tick();
        tim_line_done = 1; tim_y = 16'd1; tick(); tim_line_done = 0;
        for (int k = 0; k < 1500 && done_n == 0; k++) tick();
        repeat (3) tick();
        `CHK("pre_done_n", done_n, 1)
        `CHK("pre_gnt", gnt_n, 1)
        `CHK("pre_gpu_count", gpu_q.size(), 16)
        `CHK("pre_gpu_seq", gpu_bad(16, 32'h9000), 0)
        `CHK("pre_split", gpu_before, 6)
        `CHK("pre_disp_count", disp_q.size(), 200)
        `CHK("pre_disp_seq", disp_bad(0, 200, 400, 1'b0), 0)
        `CHK("pre_disp_bank", disp_bank, 1'b0)
        `CHK("pre_lb_bank", lb_bank, 1'b1)
        `CHK("pre_underrun", underrun, 1'b0)

        // Late trigger restarts fill at word 0 of the new line
        clr();
        ack_dly = 0;
        tim_line_done = 1; tim_y = 16'd2; tick(); tim_line_done = 0;
        for (int k = 0; k < 20 && disp_q.size() < 3; k++) tick();
        ack_en = 0;
        tick();
        `CHK("ur_before_addr", mif.mem_addr, 20'd603)
        tim_line_done = 1; tim_y = 16'd3; tick(); tim_line_done = 0;
        `CHK("ur_flag", underrun, 1'b1)
        `CHK("ur_addr", mif.mem_addr, 20'd800)
        `CHK("ur_waddr", lb_waddr, 8'd0)
        `CHK("ur_lb_bank", lb_bank, 1'b1)
        `CHK("ur_mem_rd", mif.mem_rd, 1'b1)

        // Asynchronous reset mid-fill
        rst = 1'b0;
        #1;
        `CHK("ar_mem_rd", mif.mem_rd, 1'b0)
        `CHK("ar_mem_addr", mif.mem_addr, 20'h0)
        `CHK("ar_underrun", underrun, 1'b0)
        `CHK("ar_lb_bank", lb_bank, 1'b0)
        `CHK("ar_disp_bank", disp_bank, 1'b0)
        tick();
        rst = 1'b1;
        tick();

        // Trigger on the final ack: old fill completes, next line follows
        clr();
        ack_en = 1;
        tim_frame_start = 1; tick(); tim_frame_start = 0;
        for (int k = 0; k < 300 && disp_q.size() < 200; k++) tick();
        tim_line_done = 1; tim_y = 16'd0; tick(); tim_line_done = 0;
        for (int k = 0; k < 300 && disp_q.size() < 400; k++) tick();
        repeat (3) tick();
        `CHK("edge_underrun", underrun, 1'b0)
        `CHK("edge_count", disp_q.size(), 400)
        `CHK("edge_l0_seq", disp_bad(0, 200, 0, 1'b0), 0)
        `CHK("edge_l1_seq", disp_bad(200, 200, 200, 1'b1), 0)
        `CHK("edge_disp_bank", disp_bank, 1'b1)
        `CHK("edge_lb_bank", lb_bank, 1'b0)

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
